// File: rtl/fpmul_arb_pkg.sv
// Shared types and constants for the FP multiplier arbiter.
// The round-robin arbiter is reused by the FP adder sharing block.
package fpmul_arb_pkg;

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   typedef struct packed {
      logic timeout;
      logic nan;
      logic infinit;
      logic overflow;
      logic underflow;
   } flags_t;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   localparam int unsigned FlagUnf     = 0;
   localparam int unsigned FlagOvf     = 1;
   localparam int unsigned FlagInf     = 2;
   localparam int unsigned FlagNan     = 3;
   localparam int unsigned FlagTimeout = 4;

   localparam logic [4:0] TimeoutFlags = 5'(1 << FlagTimeout) | 5'(1 << FlagNan);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward from last+1,
// wrapping around. Produces a one-hot grant and its index; all zero when disabled.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   input  logic          en_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] gnt_idx_o
);

   localparam logic [IW:0] NumReq = (IW + 1)'(N);

   logic [IW:0] sum;
   logic        found;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      sum       = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         // last_i < N and i <= N, so one conditional subtract performs the wrap
         sum = {1'b0, last_i} + (IW + 1)'(i);
         if (sum >= NumReq) begin
            sum = sum - NumReq;
         end
         if (en_i && !found && req_i[sum[IW-1:0]]) begin
            found                  = 1'b1;
            gnt_o[sum[IW-1:0]]     = 1'b1;
            gnt_idx_o              = sum[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/fpmul_arbiter.sv
// Shares one FP multiplier among N_REQ requesters: round-robin grant, start/done
// handshake, product/flag capture, tagged response, and a hung-multiplier timeout.
module fpmul_arbiter
   import fpmul_arb_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid_i,
   output logic [N_REQ-1:0]       req_ready_o,
   input  logic [N_REQ-1:0][31:0] req_a_i,
   input  logic [N_REQ-1:0][31:0] req_b_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [ID_W-1:0]        rsp_id_o,
   output logic [31:0]            rsp_product_o,
   output logic [4:0]             rsp_flags_o,
   output logic [31:0]            mul_a_o,
   output logic [31:0]            mul_b_o,
   output logic                   mul_start_o,
   input  logic                   mul_done_i,
   input  logic                   mul_nan_i,
   input  logic                   mul_inf_i,
   input  logic                   mul_ovf_i,
   input  logic                   mul_unf_i,
   input  logic [31:0]            mul_product_i
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYC);

   state_e            state_q, state_d;
   logic [31:0]       a_q, a_d, b_q, b_d;
   logic [ID_W-1:0]   id_q, id_d, last_q, last_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              done_q;
   logic [31:0]       product_q, product_d;
   logic [4:0]        flags_q, flags_d;
   logic [N_REQ-1:0]  gnt;
   logic [ID_W-1:0]   gnt_idx;
   logic              done_rise;

   rr_arbiter #(
      .N  (N_REQ),
      .IW (ID_W)
   ) u_rr_arbiter (
      .req_i     (req_valid_i),
      .last_i    (last_q),
      .en_i      (state_q == StIdle),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   // A done level already high when BUSY is entered must not count as completion
   assign done_rise = mul_done_i & ~done_q;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      id_d      = id_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      flags_d   = flags_q;
      unique case (state_q)
         StIdle: begin
            if (|gnt) begin
               a_d     = req_a_i[gnt_idx];
               b_d     = req_b_i[gnt_idx];
               id_d    = gnt_idx;
               last_d  = gnt_idx;
               cnt_d   = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            cnt_d = cnt_q + 1'b1;
            if (done_rise) begin
               product_d          = mul_product_i;
               flags_d            = '0;
               flags_d[FlagNan]   = mul_nan_i;
               flags_d[FlagInf]   = mul_inf_i;
               flags_d[FlagOvf]   = mul_ovf_i;
               flags_d[FlagUnf]   = mul_unf_i;
               state_d            = StResp;
            end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
               product_d = QNAN;
               flags_d   = TimeoutFlags;
               state_d   = StResp;
            end
         end
         StResp: begin
            if (rsp_ready_i) begin
               cnt_d   = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         a_q       <= '0;
         b_q       <= '0;
         id_q      <= '0;
         last_q    <= ID_W'(N_REQ - 1);
         cnt_q     <= '0;
         done_q    <= 1'b0;
         product_q <= '0;
         flags_q   <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         id_q      <= id_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         done_q    <= mul_done_i;
         product_q <= product_d;
         flags_q   <= flags_d;
      end
   end

   assign req_ready_o   = gnt;
   assign mul_start_o   = (state_q == StBusy);
   assign mul_a_o       = a_q;
   assign mul_b_o       = b_q;
   assign rsp_valid_o   = (state_q == StResp);
   assign rsp_id_o      = id_q;
   assign rsp_product_o = product_q;
   assign rsp_flags_o   = flags_q;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Bench for fpmul_arbiter: the bench plays the multiplier and all requesters, and
// predicts grants, latencies and responses from a round-robin reference model.
module tb_fpmul_arbiter;

   localparam int unsigned NReq = 4;
   localparam int unsigned Tmo  = 8;

   logic                  clk;
   logic                  rst_n;
   logic [NReq-1:0]       req_valid;
   logic [NReq-1:0]       req_ready;
   logic [NReq-1:0][31:0] req_a;
   logic [NReq-1:0][31:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [1:0]            rsp_id;
   logic [31:0]           rsp_product;
   logic [4:0]            rsp_flags;
   logic [31:0]           mul_a;
   logic [31:0]           mul_b;
   logic                  mul_start;
   logic                  mul_done;
   logic                  mul_nan, mul_inf, mul_ovf, mul_unf;
   logic [31:0]           mul_product;

   int          vectors;
   int          miscompares;
   int          model_last;
   int          cur_g;
   logic [31:0] exp_prod;
   logic [4:0]  exp_flags;

   fpmul_arbiter #(
      .N_REQ       (NReq),
      .TIMEOUT_CYC (Tmo)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_a_i       (req_a),
      .req_b_i       (req_b),
      .rsp_valid_o   (rsp_valid),
      .rsp_ready_i   (rsp_ready),
      .rsp_id_o      (rsp_id),
      .rsp_product_o (rsp_product),
      .rsp_flags_o   (rsp_flags),
      .mul_a_o       (mul_a),
      .mul_b_o       (mul_b),
      .mul_start_o   (mul_start),
      .mul_done_i    (mul_done),
      .mul_nan_i     (mul_nan),
      .mul_inf_i     (mul_inf),
      .mul_ovf_i     (mul_ovf),
      .mul_unf_i     (mul_unf),
      .mul_product_i (mul_product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference round robin: first valid requester after the last grant, wrapping.
   function automatic int rr_pick(input logic [NReq-1:0] v, input int last);
      for (int i = 1; i <= int'(NReq); i++) begin
         int c;
         c = (last + i) % int'(NReq);
         if (v[c]) return c;
      end
      return -1;
   endfunction

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      mul_done  = 1'b0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_mul_start", 32'(mul_start), 32'd0);
      chk("rst_product", rsp_product, 32'd0);
      chk("rst_flags_id", {rsp_flags, rsp_id}, 32'd0);
      chk("rst_mul_a", mul_a, 32'd0);
      rst_n      = 1'b1;
      model_last = NReq - 1;
   endtask

   // Called right after a negedge with req_valid already set; returns at the first BUSY negedge.
   task automatic grant_step();
      int         g;
      logic [3:0] exp_rdy;
      g = rr_pick(req_valid, model_last);
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      #1;
      chk("req_ready_grant", 32'(req_ready), 32'(exp_rdy));
      cur_g      = (g >= 0) ? g : 0;
      model_last = cur_g;
      @(negedge clk);
      req_valid[cur_g] = 1'b0;
      chk("mul_start_after_accept", 32'(mul_start), 32'd1);
      chk("mul_a_operand", mul_a, req_a[cur_g]);
      chk("mul_b_operand", mul_b, req_b[cur_g]);
      chk("req_ready_busy", 32'(req_ready), 32'd0);
   endtask

   // fl is {nan, inf, ovf, unf} as the multiplier reports them.
   task automatic complete(input int lat, input logic [31:0] prod, input logic [3:0] fl);
      repeat (lat) @(negedge clk);
      mul_done    = 1'b1;
      mul_product = prod;
      {mul_nan, mul_inf, mul_ovf, mul_unf} = fl;
      @(negedge clk);
      mul_done    = 1'b0;
      mul_product = $urandom;
      {mul_nan, mul_inf, mul_ovf, mul_unf} = 4'($urandom);
      exp_prod  = prod;
      exp_flags = {1'b0, fl};
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(cur_g));
      chk("rsp_product", rsp_product, exp_prod);
      chk("rsp_flags", 32'(rsp_flags), 32'(exp_flags));
      chk("mul_start_resp", 32'(mul_start), 32'd0);
   endtask

   task automatic accept(input int hold);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_product", rsp_product, exp_prod);
         chk("bp_flags_id", {rsp_flags, rsp_id}, {exp_flags, 2'(cur_g)});
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_mul_start", 32'(mul_start), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("rsp_valid_after_accept", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      req_valid   = '0;
      req_a       = '0;
      req_b       = '0;
      rsp_ready   = 1'b1;
      mul_done    = 1'b0;
      mul_product = '0;
      {mul_nan, mul_inf, mul_ovf, mul_unf} = 4'b0;

      do_reset();

      // Single request: 1.5 * 2.0 = 3.0
      req_a[0] = 32'h3FC0_0000;
      req_b[0] = 32'h4000_0000;
      req_valid[0] = 1'b1;
      grant_step();
      complete(3, 32'h4040_0000, 4'b0000);
      accept(0);

      // All four from reset: 1.0 * k
      do_reset();
      req_a[0] = 32'h3F80_0000; req_b[0] = 32'h3F80_0000;
      req_a[1] = 32'h3F80_0000; req_b[1] = 32'h4000_0000;
      req_a[2] = 32'h3F80_0000; req_b[2] = 32'h4040_0000;
      req_a[3] = 32'h3F80_0000; req_b[3] = 32'h4080_0000;
      req_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         grant_step();
         chk("order_grant", 32'(cur_g), 32'(k));
         complete(2, req_b[cur_g], 4'b0000);
         accept(0);
      end
      req_valid[2] = 1'b1;
      grant_step();
      chk("regrant_2", 32'(cur_g), 32'd2);
      complete(1, 32'h4040_0000, 4'b0000);
      accept(0);

      // Backpressure with requester 1 waiting
      req_a[1] = 32'h4000_0000; req_b[1] = 32'h4000_0000;
      req_a[3] = 32'h4040_0000; req_b[3] = 32'h4000_0000;
      req_valid = 4'b1010;
      grant_step();
      rsp_ready = 1'b0;
      complete(4, 32'h40C0_0000, 4'b0000);
      accept(10);
      grant_step();
      chk("grant_after_bp", 32'(cur_g), 32'd1);
      complete(0, 32'h4080_0000, 4'b0000);
      accept(0);

      // Timeout: done never rises
      req_a[0] = 32'h4000_0000; req_b[0] = 32'h4000_0000;
      req_valid = 4'b0001;
      grant_step();
      for (int i = 1; i < int'(Tmo); i++) begin
         @(negedge clk);
         chk("tmo_not_yet", 32'(rsp_valid), 32'd0);
      end
      @(negedge clk);
      exp_prod  = 32'h7FC0_0000;
      exp_flags = 5'b1_1000;
      chk("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("tmo_product", rsp_product, exp_prod);
      chk("tmo_flags", 32'(rsp_flags), 32'(exp_flags));
      accept(0);
      req_valid = 4'b0010;
      grant_step();
      complete(2, 32'h4080_0000, 4'b0000);
      accept(0);

      // Exceptions are passed through unmodified
      req_a[2] = 32'h7F80_0000; req_b[2] = 32'h0000_0000;
      req_valid = 4'b0100;
      grant_step();
      complete(3, 32'h7FC0_0000, 4'b1000);
      accept(0);
      req_a[3] = 32'h7F00_0000; req_b[3] = 32'h7F00_0000;
      req_valid = 4'b1000;
      grant_step();
      complete(3, 32'h7F80_0000, 4'b0110);
      accept(0);

      // A done level already high at entry is not a completion
      mul_done  = 1'b1;
      req_valid = 4'b0001;
      grant_step();
      repeat (3) begin
         @(negedge clk);
         chk("level_done_ignored", 32'(rsp_valid), 32'd0);
      end
      mul_done = 1'b0;
      complete(1, 32'h3F80_0000, 4'b0001);
      accept(0);

      // Randomized traffic against the round-robin model
      for (int it = 0; it < 40; it++) begin
         logic [3:0] nb;
         int         hold;
         nb = 4'($urandom);
         if ((req_valid | nb) == 4'b0) nb[$urandom_range(3, 0)] = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (nb[i] && !req_valid[i]) begin
               req_a[i] = $urandom;
               req_b[i] = $urandom;
            end
         end
         req_valid = req_valid | nb;
         grant_step();
         hold = $urandom_range(2, 0);
         if (hold > 0) rsp_ready = 1'b0;
         complete($urandom_range(Tmo - 1, 0), $urandom, 4'($urandom));
         accept(hold);
      end

      // Reset in BUSY drops the operation and restores requester 0 priority
      req_valid = '0;
      @(negedge clk);
      req_valid = 4'b0010;
      grant_step();
      complete(1, 32'h1234_5678, 4'b0000);
      accept(0);
      req_valid = 4'b0100;
      grant_step();
      @(negedge clk);
      #2;
      rst_n     = 1'b0;
      req_valid = '0;
      #1;
      chk("mid_rst_mul_start", 32'(mul_start), 32'd0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
      chk("mid_rst_mul_a", mul_a, 32'd0);
      chk("mid_rst_product", rsp_product, 32'd0);
      @(negedge clk);
      rst_n      = 1'b1;
      model_last = NReq - 1;
      repeat (3) begin
         @(negedge clk);
         chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
         chk("no_start_after_rst", 32'(mul_start), 32'd0);
      end
      req_a[0] = 32'h4000_0000; req_b[0] = 32'h3F80_0000;
      req_a[2] = 32'h4040_0000; req_b[2] = 32'h3F80_0000;
      req_valid = 4'b0101;
      grant_step();
      chk("post_rst_priority", 32'(cur_g), 32'd0);
      complete(2, 32'h4000_0000, 4'b0000);
      accept(0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
